regfile_write_queue: RTL and testbench

- Write-side initiator for the 32 x 64-bit register file.
- Collects register writebacks from two producers, the ALU path and the load/memory path, into a small in-order FIFO.
- Drains one entry per cycle onto the register file's RegWrite/RD/WriteData interface.
- Provides read-forwarding of pending (not yet committed) values so decode never reads stale RS1/RS2 data.

---
 rtl/regfile_write_queue.sv | 136 +++++++++++++
 tb/tb_regfile_write_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// Register-file write queue: merges ALU and load writebacks into an in-order FIFO,
// drains one entry per cycle to the register file and forwards pending values.
module regfile_write_queue #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      mem_ready,
  input  logic                      drain_en,
  input  logic [ADDR_W-1:0]         RS1,
  input  logic [ADDR_W-1:0]         RS2,
  output logic                      fwd1_hit,
  output logic [DATA_W-1:0]         fwd1_data,
  output logic                      fwd2_hit,
  output logic [DATA_W-1:0]         fwd2_data,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         RD,
  output logic [DATA_W-1:0]         WriteData,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  wb_t [DEPTH-1:0]   ent_q, ent_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic not_full, push, pop;
  wb_t  push_e;

  // Load path has fixed priority; ready looks only at current occupancy.
  assign not_full  = count_q < CW'(DEPTH);
  assign mem_ready = not_full;
  assign alu_ready = not_full && !mem_valid;

  always_comb begin
    push_e = mem_valid ? '{rd: mem_rd, data: mem_data} : '{rd: alu_rd, data: alu_data};
    // Accepted x0 writes complete the handshake but are dropped.
    push   = ((mem_valid && mem_ready) || (alu_valid && alu_ready)) && (push_e.rd != '0);
    pop    = drain_en && (count_q != '0);
  end

  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    regwrite_d = pop;
    rd_d       = rd_q;
    wd_d       = wd_q;
    if (push) begin
      ent_d[tail_q] = push_e;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      rd_d   = ent_q[head_q].rd;
      wd_d   = ent_q[head_q].data;
      head_d = head_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
    end else begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
    end
  end

  // Scan oldest to youngest so later matches override: output stage first, then head..tail-1.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] rs);
    logic              hit;
    logic [DATA_W-1:0] d;
    logic [PW-1:0]     idx;
    hit = 1'b0;
    d   = '0;
    if (regwrite_q && rd_q == rs) begin
      hit = 1'b1;
      d   = wd_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q && ent_q[idx].rd == rs) begin
        hit = 1'b1;
        d   = ent_q[idx].data;
      end
    end
    if (rs == '0) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_data} = lookup(RS1);
    {fwd2_hit, fwd2_data} = lookup(RS2);
  end

  assign RegWrite  = regwrite_q;
  assign RD        = rd_q;
  assign WriteData = wd_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_regfile_write_queue;
  localparam int DW = 64, AW = 5, DEPTH = 4;

  logic          clk = 1'b0, reset;
  logic          alu_valid, mem_valid, drain_en;
  logic [AW-1:0] alu_rd, mem_rd, RS1, RS2;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready, fwd1_hit, fwd2_hit, RegWrite, empty;
  logic [DW-1:0] fwd1_data, fwd2_data, WriteData;
  logic [AW-1:0] RD;
  logic [2:0]    count;

  int n_checks = 0, n_fail = 0;

  typedef struct {logic [AW-1:0] rd; logic [DW-1:0] d;} ent_t;
  ent_t          mq[$];
  logic          m_rw;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wd;

  regfile_write_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .drain_en(drain_en), .RS1(RS1), .RS2(RS2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .count(count), .empty(empty));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; drain_en = 0;
    alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0; RS1 = 0; RS2 = 0;
  endtask

  // Reference forwarding: youngest matching pending write, else output stage, x0 never hits.
  function automatic logic [DW:0] fwd_model(input logic [AW-1:0] rs);
    logic [DW:0] r;
    r = '0;
    if (rs != 0) begin
      if (m_rw && m_rd == rs) r = {1'b1, m_wd};
      foreach (mq[i]) if (mq[i].rd == rs) r = {1'b1, mq[i].d};
    end
    return r;
  endfunction

  task automatic test_reset();
    idle();
    reset = 0;
    repeat (2) step();
    reset = 1;
    #1;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
    n_checks++; if (RD !== '0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", RD); end
    n_checks++; if (WriteData !== '0) begin n_fail++; $display("FAIL reset_wd got %h want 0", WriteData); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready got %b want 1", alu_ready); end
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready got %b want 1", mem_ready); end
  endtask

  task automatic test_single_alu();
    step();
    alu_valid = 1; alu_rd = 5; alu_data = 64'h1234; drain_en = 1;
    step();
    alu_valid = 0;
    n_checks++; if (count !== 3'd1 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL single_enq count %0d rw %b want 1 0", count, RegWrite); end
    step();
    n_checks++; if (RegWrite !== 1'b1 || RD !== 5'd5 || WriteData !== 64'h1234) begin
      n_fail++; $display("FAIL single_write rw %b rd %0d wd %h want 1 5 1234", RegWrite, RD, WriteData); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count got %0d want 0", count); end
    step();
    n_checks++; if (RegWrite !== 1'b0 || RD !== 5'd5) begin n_fail++; $display("FAIL single_pulse rw %b rd %0d want 0 5", RegWrite, RD); end
  endtask

  task automatic test_priority_fill();
    idle();
    mem_valid = 1; alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
    for (int i = 1; i <= 4; i++) begin
      mem_rd = AW'(i); mem_data = 64'(100 + i);
      #1;
      n_checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
        n_fail++; $display("FAIL prio_ready[%0d] alu %b mem %b want 0 1", i, alu_ready, mem_ready); end
      step();
    end
    n_checks++; if (count !== 3'd4 || mem_ready !== 1'b0 || empty !== 1'b0) begin
      n_fail++; $display("FAIL fill_full count %0d mem_ready %b empty %b want 4 0 0", count, mem_ready, empty); end
    mem_valid = 0;
    #1;
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL fill_alu_ready got %b want 0", alu_ready); end
    alu_valid = 0; drain_en = 1;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++; if (RegWrite !== 1'b1 || RD !== AW'(i) || WriteData !== 64'(100 + i)) begin
        n_fail++; $display("FAIL drain_order[%0d] rw %b rd %0d wd %0d want 1 %0d %0d", i, RegWrite, RD, WriteData, i, 100 + i); end
    end
    step();
    n_checks++; if (RegWrite !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL drain_done rw %b count %0d empty %b want 0 0 1", RegWrite, count, empty); end
  endtask

  task automatic test_forwarding();
    idle();
    alu_valid = 1; alu_rd = 7; alu_data = 64'hA;
    step();
    alu_data = 64'hB;
    step();
    alu_valid = 0; RS1 = 7; RS2 = 0;
    #1;
    n_checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 64'hB) begin n_fail++; $display("FAIL fwd_youngest hit %b data %h want 1 b", fwd1_hit, fwd1_data); end
    n_checks++; if (fwd2_hit !== 1'b0 || fwd2_data !== '0) begin n_fail++; $display("FAIL fwd_x0 hit %b data %h want 0 0", fwd2_hit, fwd2_data); end
    drain_en = 1;
    step();
    n_checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 64'hB) begin n_fail++; $display("FAIL fwd_vs_out hit %b data %h want 1 b", fwd1_hit, fwd1_data); end
    step();
    n_checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 64'hB) begin n_fail++; $display("FAIL fwd_out_stage hit %b data %h want 1 b", fwd1_hit, fwd1_data); end
    step();
    n_checks++; if (fwd1_hit !== 1'b0 || fwd1_data !== '0) begin n_fail++; $display("FAIL fwd_gone hit %b data %h want 0 0", fwd1_hit, fwd1_data); end
  endtask

  task automatic test_x0_discard();
    idle();
    drain_en = 1; alu_valid = 1; alu_rd = 0; alu_data = 64'hFFFF;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b want 1", alu_ready); end
    step();
    alu_valid = 0;
    n_checks++; if (count !== 3'd0 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL x0_count count %0d rw %b want 0 0", count, RegWrite); end
    step();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL x0_nowrite got %b want 0", RegWrite); end
  endtask

  task automatic test_reset_mid();
    idle();
    alu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_rd = AW'(10 + i); alu_data = 64'(i + 1);
      step();
    end
    alu_valid = 0; drain_en = 1;
    step();
    n_checks++; if (count !== 3'd3 || RegWrite !== 1'b1) begin n_fail++; $display("FAIL mid_pre count %0d rw %b want 3 1", count, RegWrite); end
    #2 reset = 0;
    #1;
    n_checks++; if (RegWrite !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL mid_async rw %b count %0d empty %b want 0 0 1", RegWrite, count, empty); end
    step();
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (RegWrite !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL mid_after[%0d] rw %b count %0d want 0 0", i, RegWrite, count); end
    end
  endtask

  task automatic test_random();
    logic        e_ar, e_mr, pop;
    logic [DW:0] f1, f2;
    ent_t        e;
    idle();
    mq.delete(); m_rw = 0; m_rd = 0; m_wd = 0;
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(0, 2) != 0); mem_valid = ($urandom_range(0, 2) == 0);
      alu_rd = AW'($urandom_range(0, 7)); mem_rd = AW'($urandom_range(0, 7));
      alu_data = {$urandom, $urandom}; mem_data = {$urandom, $urandom};
      drain_en = ($urandom_range(0, 1) == 1);
      RS1 = AW'($urandom_range(0, 7)); RS2 = AW'($urandom_range(0, 7));
      #1;
      e_mr = mq.size() < DEPTH;
      e_ar = e_mr && !mem_valid;
      f1 = fwd_model(RS1); f2 = fwd_model(RS2);
      n_checks++; if (alu_ready !== e_ar || mem_ready !== e_mr) begin
        n_fail++; $display("FAIL rnd_ready[%0d] alu %b mem %b want %b %b", c, alu_ready, mem_ready, e_ar, e_mr); end
      n_checks++; if ({fwd1_hit, fwd1_data} !== f1) begin
        n_fail++; $display("FAIL rnd_fwd1[%0d] got %b/%h want %b/%h", c, fwd1_hit, fwd1_data, f1[DW], f1[DW-1:0]); end
      n_checks++; if ({fwd2_hit, fwd2_data} !== f2) begin
        n_fail++; $display("FAIL rnd_fwd2[%0d] got %b/%h want %b/%h", c, fwd2_hit, fwd2_data, f2[DW], f2[DW-1:0]); end
      pop = drain_en && mq.size() > 0;
      @(posedge clk);
      m_rw = pop;
      if (pop) begin e = mq.pop_front(); m_rd = e.rd; m_wd = e.d; end
      if (mem_valid && e_mr && mem_rd != 0) mq.push_back('{rd: mem_rd, d: mem_data});
      else if (alu_valid && e_ar && alu_rd != 0) mq.push_back('{rd: alu_rd, d: alu_data});
      #1;
      n_checks++; if (RegWrite !== m_rw || RD !== m_rd || WriteData !== m_wd) begin
        n_fail++; $display("FAIL rnd_out[%0d] rw %b rd %0d wd %h want %b %0d %h", c, RegWrite, RD, WriteData, m_rw, m_rd, m_wd); end
      n_checks++; if (count !== 3'(mq.size()) || empty !== (mq.size() == 0)) begin
        n_fail++; $display("FAIL rnd_count[%0d] count %0d empty %b want %0d", c, count, empty, mq.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_priority_fill();
    test_forwarding();
    test_x0_discard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
